uart_word_tx: RTL and testbench
===============================

# uart_word_tx

Parametrised multi-byte UART transmitter. Captures a `WORD_BYTES`-byte word on each rising edge of `wr_uart` into a word FIFO, then serialises each word as back-to-back 8N1 frames (optional parity) on `tx`. It sits between the datapath (accumulator or any register) and the board TX pin. It contains its own baud tick generator, edge detector, buffering and frame FSM.

## Interface
- `CLK_MHZ`, 100: system clock frequency in MHz.
- `BAUD_RATE`, 19200: line rate in bit/s.
- `WORD_BYTES`, 2: bytes per captured word, from 1 to 8.
- `FIFO_DEPTH`, 4: word FIFO depth, a power of two, at least 2.
- `MSB_FIRST`, 1: 1 sends the most significant byte first; 0 sends the least significant byte first. Bits within a byte are always sent LSB first.
- `SB_TICK`, 16: stop-bit length in oversample ticks. 16 gives 1 stop bit; 32 gives 2 stop bits.

- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `wr_uart` in 1: write request, level signal. Only its rising edge captures a word.
- `data_in` in `WORD_BYTES*8`: word sampled on the capture cycle.
- `tx` out 1: serial line, idles high.
- `busy` out 1: high while a frame is in progress or the FIFO is non-empty.
- `full` out 1: word FIFO full.
- `overflow` out 1: sticky. Set when a capture is dropped. Cleared only by `reset`.

## Operation
- Reset (synchronous, active-high): all of the following take effect at the next `clk` edge.
  - `tx`=1, `busy`=0, `full`=0, `overflow`=0.
  - FIFO is emptied and the FSM goes to IDLE.
  - The baud counter is cleared.
  - The edge-detect register is set to 1, so a `wr_uart` held high through reset is not captured.
- Capture: `wr_q` registers `wr_uart`. A capture occurs on a cycle where `wr_uart`=1 and `wr_q`=0.
  - If not full: push `data_in`.
  - If full: drop the word and set `overflow`.
  - Pop and push in the same cycle while full: the push is accepted and the count is unchanged.
- Baud tick: `DIV = CLK_MHZ*1_000_000 / (BAUD_RATE*16)`, integer floor, minimum 1. A tick pulses once every `DIV` cycles.
  - The counter is held at 0 in IDLE, so every bit lasts exactly `16*DIV` cycles.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: if the FIFO is non-empty, pop the word into the word shift register, set byte index to 0, go to START.
  - START: `tx`=0 for 16 ticks, then go to DATA with bit index 0.
  - DATA: `tx`=current byte bit[idx] for 16 ticks each. After 8 bits go to PARITY or STOP.
  - STOP: `tx`=1 for `SB_TICK` ticks. Then:
    - If byte index < `WORD_BYTES-1`: advance the byte and go to START with no idle gap.
    - Otherwise, if the FIFO is non-empty: pop and go to START directly.
    - Otherwise: go to IDLE.
- Byte selection comes from the word shift register. It shifts left 8 when `MSB_FIRST`=1 and right 8 when `MSB_FIRST`=0.
- A word is popped only when its first frame starts. `data_in` changes after capture never affect queued words.

## Timing
- Capture at edge k:
  - FIFO is non-empty after edge k.
  - Pop at edge k+1.
  - `tx` falls after edge k+2. This is the start-bit latency of 2 cycles from the capture edge.
- `busy` rises after edge k. It falls on the cycle the FSM re-enters IDLE with the FIFO empty.
- Word duration is `WORD_BYTES * (16*(9+P) + SB_TICK) * DIV` cycles, where P=1 with parity and 0 without.
- `full` and `overflow` update one cycle after the causing edge, i.e. they are registered.
- Reset mid-frame: `tx` is high after the reset edge. The partial frame is abandoned and queued words are lost.

## Configuration
- `UART_WORD_TX_PARITY_EN`
  - Defined: the PARITY state is inserted after DATA. `tx` = XOR of the 8 data bits (even parity) for 16 ticks.
  - Undefined: DATA goes directly to STOP, and no parity logic is synthesised.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - Oversample constant 16.
  - DIV computation function.
  - Parity function.
- One sub-module, `uart_word_fifo`: synchronous FIFO holding `FIFO_DEPTH` words, with wrapping pointers and a count register.
- Edge detect, baud counter and FSM stay in the top module.

## Test plan
Benches use `CLK_MHZ`=1, `BAUD_RATE`=62500, giving DIV=1 and 16 cycles per bit.
- Reset with `wr_uart` held high, then release reset: no capture, `tx`=1, `busy`=0 throughout.
- One pulse with `data_in`=16'hA53C, `MSB_FIRST`=1: `tx` falls 2 cycles after capture.
  - Bytes A5 then 3C, each sent LSB first, with no gap between the stop bit and the next start bit.
  - `busy` drops after 320 cycles.
- Same word with `MSB_FIRST`=0: order is 3C then A5.
- Five captures 10 cycles apart with `FIFO_DEPTH`=4: the first pops immediately, the remaining four fill the FIFO, all 5 words are sent, and `overflow` stays 0.
  - A sixth capture while `full`=1: the word is dropped and `overflow`=1 sticks until reset.
- Assert `reset` at cycle 100 of a frame: `tx`=1 the next cycle, the FIFO is empty and `busy`=0.
- With `UART_WORD_TX_PARITY_EN` defined, `data_in`=16'h0701: parity bits are 1 for byte 07 and 1 for byte 01; each frame is 176 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the multi-byte UART transmitter.
//   state_e    : frame FSM states
//   Oversample : ticks per bit
//   calc_div   : baud divider from clock (MHz) and line rate (bit/s), floor, minimum 1
//   parity8    : even parity of one byte
package uart_pkg;

  localparam int unsigned Oversample = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  function automatic int unsigned calc_div(input int unsigned clk_mhz,
                                           input int unsigned baud);
    int unsigned d;
    d = (clk_mhz * 1000000) / (baud * Oversample);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO with wrapping pointers and an occupancy count.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and data (ignored when full unless popping)
//   pop_i, rdata_o    : read request and head-of-queue data (combinational)
//   empty_o, full_o   : status, derived from the count register
module uart_word_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign rdata_o = mem_q[rd_ptr_q];

  // A push while full is accepted only when a pop frees the head slot in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: captures a word on each rising edge of wr_uart into a
// word FIFO and sends it as back-to-back 8N1 frames (even parity when
// UART_WORD_TX_PARITY_EN is defined).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   wr_uart    : write request level; its rising edge captures data_in
//   data_in    : WORD_BYTES*8-bit word
//   tx         : serial line, idles high (registered)
//   busy       : frame in progress or FIFO non-empty
//   full       : word FIFO full
//   overflow   : sticky, a capture was dropped
// Optional feature macro: UART_WORD_TX_PARITY_EN
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_MHZ    = 100,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned SB_TICK    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_uart,
  input  logic [WORD_BYTES*8-1:0] data_in,
  output logic                    tx,
  output logic                    busy,
  output logic                    full,
  output logic                    overflow
);

  localparam int unsigned Div   = calc_div(CLK_MHZ, BAUD_RATE);
  localparam int unsigned CntW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned WordW = WORD_BYTES * 8;
  localparam int unsigned TickW = 8;

  localparam logic [CntW-1:0]  LastCnt  = CntW'(Div - 1);
  localparam logic [TickW-1:0] LastBit  = TickW'(Oversample - 1);
  localparam logic [TickW-1:0] LastSb   = TickW'(SB_TICK - 1);
  localparam logic [2:0]       LastByte = 3'(WORD_BYTES - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  baud_q, baud_d;
  logic [TickW-1:0] s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [2:0]       b_q, b_d;
  logic [WordW-1:0] word_q, word_d;
  logic             wr_q;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             capture, pop, tick;
  logic [WordW-1:0] fifo_rdata;
  logic             fifo_empty, fifo_full;
  logic [7:0]       cur_byte;
  logic [WordW-1:0] word_next;

  assign capture = wr_uart && !wr_q;

  uart_word_fifo #(
    .Width(WordW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (capture),
    .wdata_i(data_in),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // Counter parked at 0 in idle so the first bit of a frame is full length.
  assign tick = (state_q != StIdle) && (baud_q == LastCnt);

  always_comb begin
    baud_d = baud_q;
    if (state_q == StIdle || tick) baud_d = '0;
    else                           baud_d = baud_q + 1'b1;
  end

  assign cur_byte  = (MSB_FIRST != 0) ? word_q[WordW-1 -: 8] : word_q[7:0];
  assign word_next = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = fifo_rdata;
          b_d     = '0;
          s_d     = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == LastBit) begin
            s_d     = '0;
            n_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == LastBit) begin
            s_d = '0;
            if (n_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (s_q == LastBit) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (s_q == LastSb) begin
            s_d = '0;
            if (b_q != LastByte) begin
              b_d     = b_q + 1'b1;
              word_d  = word_next;
              state_d = StStart;
            end else if (!fifo_empty) begin
              // Chain straight into the next queued word, no idle gap.
              pop     = 1'b1;
              word_d  = fifo_rdata;
              b_d     = '0;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is registered from the current state, giving a glitch-free pin.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = cur_byte[n_q];
`ifdef UART_WORD_TX_PARITY_EN
      StParity: tx_d = parity8(cur_byte);
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign ovf_d = ovf_q | (capture && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      word_q  <= '0;
      wr_q    <= 1'b1;  // a request held through reset is not a rising edge
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      word_q  <= word_d;
      wr_q    <= wr_uart;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;
  assign full     = fifo_full;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

`ifdef UART_WORD_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FrameCyc = 16 * (9 + P) + 16;
  localparam int WordCyc  = 2 * FrameCyc;
  localparam int MaxRec   = 5 * WordCyc + 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_uart = 1'b0;
  logic [15:0] data_in = '0;
  logic        tx_m, busy_m, full_m, ovf_m;
  logic        tx_l, busy_l, full_l, ovf_l;

  always #5 clk = ~clk;

  uart_word_tx #(
    .CLK_MHZ(1), .BAUD_RATE(62500), .WORD_BYTES(2), .FIFO_DEPTH(4), .MSB_FIRST(1),
    .SB_TICK(16)
  ) dut_m (
    .clk(clk), .reset(reset), .wr_uart(wr_uart), .data_in(data_in),
    .tx(tx_m), .busy(busy_m), .full(full_m), .overflow(ovf_m)
  );

  uart_word_tx #(
    .CLK_MHZ(1), .BAUD_RATE(62500), .WORD_BYTES(2), .FIFO_DEPTH(4), .MSB_FIRST(0),
    .SB_TICK(16)
  ) dut_l (
    .clk(clk), .reset(reset), .wr_uart(wr_uart), .data_in(data_in),
    .tx(tx_l), .busy(busy_l), .full(full_l), .overflow(ovf_l)
  );

  int checks = 0;
  int errors = 0;

  logic rt_m [MaxRec];
  logic rt_l [MaxRec];
  logic rb   [MaxRec];
  logic rf   [MaxRec];
  logic ro   [MaxRec];
  logic [15:0] fw [6];

  typedef struct {
    logic [15:0] data;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // c = 0 is the sample just after the first capture edge.
  task automatic run_record(input int n, input bit fifo_mode);
    for (int c = 0; c < n; c++) begin
      step();
      rt_m[c] = tx_m;
      rt_l[c] = tx_l;
      rb[c]   = busy_m;
      rf[c]   = full_m;
      ro[c]   = ovf_m;
      if (fifo_mode && ((c + 1) % 10 == 0) && (c + 1) <= 50) begin
        wr_uart = 1'b1;
        data_in = fw[(c + 1) / 10];
      end else begin
        wr_uart = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string nm, input int base, input logic [7:0] exp,
                             input bit lsb_dut);
    logic [7:0] got;
    logic       st, sp;
    for (int i = 0; i < 8; i++) got[i] = lsb_dut ? rt_l[base + 16 * (1 + i) + 8]
                                                 : rt_m[base + 16 * (1 + i) + 8];
    st = lsb_dut ? rt_l[base + 8] : rt_m[base + 8];
    sp = lsb_dut ? rt_l[base + 16 * (9 + P) + 8] : rt_m[base + 16 * (9 + P) + 8];
    chk({nm, " start"}, 32'(st), 32'd0);
    chk({nm, " data"}, 32'(got), 32'(exp));
`ifdef UART_WORD_TX_PARITY_EN
    chk({nm, " parity"}, 32'(lsb_dut ? rt_l[base + 16 * 9 + 8] : rt_m[base + 16 * 9 + 8]),
        32'(^exp));
`endif
    chk({nm, " stop"}, 32'(sp), 32'd1);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 16'hA53C, hi: 8'hA5, lo: 8'h3C};
    vecs[1] = '{data: 16'h0701, hi: 8'h07, lo: 8'h01};
    vecs[2] = '{data: 16'hFF00, hi: 8'hFF, lo: 8'h00};
    vecs[3] = '{data: 16'h8001, hi: 8'h80, lo: 8'h01};
    fw[0] = 16'h1101; fw[1] = 16'h2202; fw[2] = 16'h3303;
    fw[3] = 16'h4404; fw[4] = 16'h5505; fw[5] = 16'hDEAD;

    // Reset with wr_uart held high: nothing is captured.
    reset = 1'b1;
    wr_uart = 1'b1;
    data_in = 16'hFFFF;
    repeat (3) step();
    chk("reset tx", 32'(tx_m), 32'd1);
    chk("reset busy", 32'(busy_m), 32'd0);
    chk("reset full", 32'(full_m), 32'd0);
    chk("reset overflow", 32'(ovf_m), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("hold tx c%0d", i), 32'(tx_m), 32'd1);
      chk($sformatf("hold busy c%0d", i), 32'(busy_m), 32'd0);
    end
    wr_uart = 1'b0;
    repeat (3) step();

    // Single-word vectors on both byte orders.
    for (int v = 0; v < 4; v++) begin
      wr_uart = 1'b1;
      data_in = vecs[v].data;
      run_record(WordCyc + 20, 1'b0);
      chk($sformatf("v%0d busy rise", v), 32'(rb[0]), 32'd1);
      chk($sformatf("v%0d tx c1", v), 32'(rt_m[1]), 32'd1);
      chk($sformatf("v%0d tx fall c2", v), 32'(rt_m[2]), 32'd0);
      check_frame($sformatf("v%0d msb b0", v), 2, vecs[v].hi, 1'b0);
      check_frame($sformatf("v%0d msb b1", v), 2 + FrameCyc, vecs[v].lo, 1'b0);
      check_frame($sformatf("v%0d lsb b0", v), 2, vecs[v].lo, 1'b1);
      check_frame($sformatf("v%0d lsb b1", v), 2 + FrameCyc, vecs[v].hi, 1'b1);
      chk($sformatf("v%0d busy last", v), 32'(rb[WordCyc]), 32'd1);
      chk($sformatf("v%0d busy fall", v), 32'(rb[WordCyc + 1]), 32'd0);
      chk($sformatf("v%0d tx idle", v), 32'(rt_m[WordCyc + 5]), 32'd1);
      repeat (3) step();
    end

    // Six captures 10 cycles apart: four queue behind the first, the sixth is dropped.
    wr_uart = 1'b1;
    data_in = fw[0];
    run_record(MaxRec, 1'b1);
    chk("fifo full before", 32'(rf[39]), 32'd0);
    chk("fifo full", 32'(rf[40]), 32'd1);
    chk("fifo ovf before", 32'(ro[49]), 32'd0);
    chk("fifo ovf set", 32'(ro[50]), 32'd1);
    for (int w = 0; w < 5; w++) begin
      check_frame($sformatf("fifo w%0d b0", w), 2 + w * WordCyc, fw[w][15:8], 1'b0);
      check_frame($sformatf("fifo w%0d b1", w), 2 + w * WordCyc + FrameCyc, fw[w][7:0], 1'b0);
    end
    chk("fifo busy last", 32'(rb[5 * WordCyc]), 32'd1);
    chk("fifo busy fall", 32'(rb[5 * WordCyc + 1]), 32'd0);
    chk("fifo ovf sticky", 32'(ovf_m), 32'd1);

    // Reset 100 cycles into a frame with a second word queued.
    wr_uart = 1'b1;
    data_in = 16'hA53C;
    step();
    wr_uart = 1'b0;
    repeat (9) step();
    wr_uart = 1'b1;
    data_in = 16'h1234;
    step();
    wr_uart = 1'b0;
    repeat (90) step();
    chk("mid busy pre", 32'(busy_m), 32'd1);
    reset = 1'b1;
    step();
    chk("mid tx", 32'(tx_m), 32'd1);
    chk("mid busy", 32'(busy_m), 32'd0);
    chk("mid full", 32'(full_m), 32'd0);
    chk("mid overflow", 32'(ovf_m), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("post tx c%0d", i), 32'(tx_m), 32'd1);
      chk($sformatf("post busy c%0d", i), 32'(busy_m), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
